// File: rtl/limn2600_mem_arbiter_pkg.sv
// Shared types and constants for the Limn2600 on-chip memory arbiter.
package limn2600_mem_pkg;

  localparam int MEM_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_NVRAM,
    REGION_ROM
  } mem_region_t;

  // Upper address halfword at which each memory region starts.
  localparam logic [15:0] RAM_BASE   = 16'h0000;
  localparam logic [15:0] NVRAM_BASE = 16'hF800;
  localparam logic [15:0] ROM_BASE   = 16'hFFFE;

  function automatic logic [15:0] region_base(input mem_region_t region);
    case (region)
      REGION_RAM:   region_base = RAM_BASE;
      REGION_NVRAM: region_base = NVRAM_BASE;
      default:      region_base = ROM_BASE;
    endcase
  endfunction

  function automatic logic is_word_aligned(input logic [MEM_ADDR_WIDTH-1:0] addr);
    is_word_aligned = (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/limn2600_mem_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter; slave = arbiter view, master = environment view.
interface limn2600_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  import limn2600_mem_pkg::*;

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_we;
  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0]                resp_valid;
  logic                              resp_err;
  logic [DATA_WIDTH-1:0]             resp_rdata;
  logic                              mem_cs;
  logic                              mem_we;
  logic [MEM_ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]             mem_wdata;
  logic [DATA_WIDTH-1:0]             mem_rdata;
  logic                              mem_rdy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_rdy,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_rdy,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_cs, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/limn2600_rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, wrapping modulo NUM_REQ.
module limn2600_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    // k=NUM_REQ wraps back to last_grant itself, so a lone repeat requester still wins.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/limn2600_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported Limn2600 memory between NUM_REQ requesters.
module limn2600_mem_arbiter
  import limn2600_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  limn2600_mem_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  arb_state_t                state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]          last_q, last_d;
  logic [IDX_W-1:0]          gidx_q, gidx_d;
  logic                      cs_q, cs_d;
  logic                      we_q, we_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [NUM_REQ-1:0]        resp_valid_q, resp_valid_d;
  logic                      resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]     resp_rdata_q, resp_rdata_d;

  logic [NUM_REQ-1:0]        req_eff;
  logic [NUM_REQ-1:0]        grant_oh;
  logic [IDX_W-1:0]          grant_idx;
  logic [MEM_ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0]     win_wdata;
  logic                      win_we;

  // Requests are only visible to the picker in IDLE, and never while reset is held.
  assign req_eff = (state_q == IDLE && !rst) ? bus.req_valid : '0;

  limn2600_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_eff),
    .last_grant (last_q),
    .grant      (grant_oh),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        win_addr  = bus.req_addr[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
        win_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        win_we    = bus.req_we[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    gidx_d       = gidx_q;
    cs_d         = cs_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = '0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (|req_eff) begin
          last_d  = grant_idx;
          gidx_d  = grant_idx;
          we_d    = win_we;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          // Misaligned accesses are answered locally and never reach the memory.
          if (!is_word_aligned(win_addr)) begin
            resp_valid_d = grant_oh;
            resp_err_d   = 1'b1;
          end else begin
            cs_d    = 1'b1;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        cs_d    = 1'b0;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_rdy) begin
          resp_valid_d         = '0;
          resp_valid_d[gidx_q] = 1'b1;
          resp_rdata_d         = we_q ? '0 : bus.mem_rdata;
          state_d              = IDLE;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          resp_valid_d         = '0;
          resp_valid_d[gidx_q] = 1'b1;
          resp_err_d           = 1'b1;
          state_d              = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= IDX_W'(NUM_REQ - 1);
      gidx_q       <= '0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      gidx_q       <= gidx_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = grant_oh;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_cs     = cs_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_limn2600_mem_arbiter.sv
// Directed bench for limn2600_mem_arbiter with a one-cycle-ready SRAM model.
module tb_limn2600_mem_arbiter;

  localparam int DW = 32;
  localparam int NR = 2;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  limn2600_mem_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  limn2600_mem_arbiter #(
    .DATA_WIDTH     (DW),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // SRAM model: word i holds i after reset; ready one cycle after a sampled chip select.
  logic [DW-1:0] mem [256];
  logic          mdl_rdy;
  logic [DW-1:0] mdl_rdata;
  logic          stall;
  logic          inj_rdy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_rdy   <= 1'b0;
      mdl_rdata <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
    end else begin
      mdl_rdy <= 1'b0;
      if (bus.mem_cs && !stall) begin
        mdl_rdy <= 1'b1;
        if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        else            mdl_rdata <= mem[bus.mem_addr[9:2]];
      end
    end
  end

  assign bus.mem_rdy   = mdl_rdy | inj_rdy;
  assign bus.mem_rdata = mdl_rdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          idx;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_cs;
  } vec_t;

  vec_t vecs [8];

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"},  32'(bus.req_ready),  32'd0);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_resp_err"},   32'(bus.resp_err),   32'd0);
    check({tag, "_resp_rdata"}, bus.resp_rdata,      32'd0);
    check({tag, "_mem_cs"},     32'(bus.mem_cs),     32'd0);
    check({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
    check({tag, "_mem_addr"},   bus.mem_addr,        32'd0);
    check({tag, "_mem_wdata"},  bus.mem_wdata,       32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one request, then follow it to its response, tracking latency and chip selects.
  task automatic do_access(input string tag, input vec_t v);
    int n;
    int lat;
    int cs_cnt;
    int cs_at;
    bit got;
    @(negedge clk);
    bus.req_valid                    = '0;
    bus.req_valid[v.idx]             = 1'b1;
    bus.req_we[v.idx]                = v.we;
    bus.req_addr[v.idx*32 +: 32]     = v.addr;
    bus.req_wdata[v.idx*DW +: DW]    = v.wdata;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_ready_wait"}, 32'(n), 32'd0);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << v.idx));
    cs_cnt = 0;
    cs_at  = -1;
    got    = 1'b0;
    @(negedge clk);
    bus.req_valid = '0;
    lat = 1;
    while (!got && lat < 40) begin
      if (bus.mem_cs) begin
        cs_cnt++;
        cs_at = lat;
      end
      if (bus.resp_valid != '0) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'(1 << v.idx));
    check({tag, "_resp_err"},   32'(bus.resp_err),   32'(v.exp_err));
    check({tag, "_resp_rdata"}, bus.resp_rdata,      v.exp_rdata);
    check({tag, "_latency"},    32'(lat),            32'(v.exp_lat));
    check({tag, "_cs_count"},   32'(cs_cnt),         32'(v.exp_cs));
    if (v.exp_cs != 0) check({tag, "_cs_cycle"}, 32'(cs_at), 32'd1);
    @(negedge clk);
    check({tag, "_resp_clear"}, 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic expect_no_resp(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.resp_valid != '0) seen++;
    end
    check({tag, "_no_resp"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   gidx  [8];
    int   gcyc  [8];
    int   ng;
    int   rcnt;
    int   cs_cnt;
    logic [31:0] rexp;

    vecs[0] = '{0, 1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'h0000_0004, 3, 1};
    vecs[1] = '{1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF,  1'b0, 32'h0,         3, 1};
    vecs[2] = '{0, 1'b0, 32'h0000_0100, 32'h0,          1'b0, 32'hDEAD_BEEF, 3, 1};
    vecs[3] = '{0, 1'b0, 32'h0000_0002, 32'h0,          1'b1, 32'h0,         1, 0};
    vecs[4] = '{1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFF,  1'b1, 32'h0,         1, 0};
    vecs[5] = '{1, 1'b0, 32'h0000_0008, 32'h0,          1'b0, 32'h0000_0002, 3, 1};
    vecs[6] = '{0, 1'b1, 32'h0000_0020, 32'h1234_5678,  1'b0, 32'h0,         3, 1};
    vecs[7] = '{1, 1'b0, 32'h0000_0020, 32'h0,          1'b0, 32'h1234_5678, 3, 1};

    bus.req_valid = '1;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    stall         = 1'b0;
    inj_rdy       = 1'b0;

    // Reset state, with requests pending to show req_ready is held off.
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    bus.req_valid = '0;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) do_access($sformatf("vec%0d", i), vecs[i]);

    // Continuous contention from reset: grants 0,1,0,1,0 spaced three cycles apart.
    do_reset();
    @(negedge clk);
    bus.req_we    = '0;
    bus.req_addr  = {32'h0000_0008, 32'h0000_0010};
    bus.req_valid = 2'b11;
    ng = 0; rcnt = 0; cs_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (bus.req_ready != '0 && ng < 8) begin
        gidx[ng] = (bus.req_ready == 2'b10) ? 1 : 0;
        gcyc[ng] = c;
        ng++;
      end
      if (bus.mem_cs) cs_cnt++;
      if (bus.resp_valid != '0) begin
        rexp = (rcnt % 2 == 0) ? 32'h4 : 32'h2;
        check($sformatf("cont_resp%0d_who", rcnt), 32'(bus.resp_valid), 32'(1 << (rcnt % 2)));
        check($sformatf("cont_resp%0d_rdata", rcnt), bus.resp_rdata, rexp);
        rcnt++;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    check("cont_grants", 32'(ng), 32'd5);
    check("cont_cs_count", 32'(cs_cnt), 32'd5);
    check("cont_resp_count", 32'(rcnt), 32'd4);
    for (int k = 0; k < 5; k++) begin
      if (k < ng) begin
        check($sformatf("cont_grant%0d_idx", k), 32'(gidx[k]), 32'(k % 2));
        check($sformatf("cont_grant%0d_cycle", k), 32'(gcyc[k]), 32'(3 * k));
      end
    end
    repeat (5) @(negedge clk);

    // Timeout: no ready for TO wait cycles, then a stale ready must be ignored.
    stall = 1'b1;
    v = '{0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h0, TO + 2, 1};
    do_access("timeout", v);
    stall = 1'b0;
    @(negedge clk);
    inj_rdy = 1'b1;
    @(negedge clk);
    inj_rdy = 1'b0;
    expect_no_resp("late_rdy", 3);
    v = '{1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0000_0004, 3, 1};
    do_access("after_timeout", v);

    // Reset asserted mid-WAIT clears outputs without a clock edge.
    stall = 1'b1;
    @(negedge clk);
    bus.req_valid    = 2'b10;
    bus.req_we       = '0;
    bus.req_addr     = {32'h0000_0008, 32'h0};
    @(negedge clk);
    bus.req_valid    = '0;
    repeat (2) @(negedge clk);
    check("midwait_addr", bus.mem_addr, 32'h0000_0008);
    #2;
    rst = 1'b1;
    bus.req_valid = 2'b01;
    #1;
    check_outputs_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    stall = 1'b0;
    inj_rdy = 1'b1;
    @(negedge clk);
    inj_rdy = 1'b0;
    expect_no_resp("post_rst_rdy", 3);
    v = '{1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h0000_0002, 3, 1};
    do_access("post_rst_read", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/limn2600_mem_arbiter.md
Name: limn2600_mem_arbiter

Overview:
Shares the single-ported Limn2600 SRAM/ROM/NVRAM block between NUM_REQ requesters, such as instruction fetch and load/store. It arbitrates round-robin, issues exactly one chip-select pulse per accepted access, waits for the memory ready strobe and routes the response back to the winner. It also rejects misaligned accesses and recovers from a missing ready via timeout.

Parameters:
DATA_WIDTH, 32, data bus width; matches the SRAM.
NUM_REQ, 2, number of requesters (2..4).
TIMEOUT_CYCLES, 15, WAIT cycles without mem_rdy before an error response (1..255).

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-high.
req_valid  input  NUM_REQ  per-requester request; requester holds all fields until its req_ready.
req_we  input  NUM_REQ  1 = write, 0 = read.
req_addr  input  NUM_REQ*32  byte address, slice i = requester i.
req_wdata  input  NUM_REQ*DATA_WIDTH  write data, slice i = requester i.
req_ready  output  NUM_REQ  one-hot accept pulse (combinational, IDLE only).
resp_valid  output  NUM_REQ  one-hot, one-cycle registered response strobe.
resp_err  output  1  qualifies resp_valid: misaligned or timeout.
resp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
mem_cs  output  1  SRAM chip select.
mem_we  output  1  SRAM write enable.
mem_addr  output  32  SRAM address.
mem_wdata  output  DATA_WIDTH  to SRAM data_in.
mem_rdata  input  DATA_WIDTH  from SRAM data_out.
mem_rdy  input  1  SRAM ready; registered, one cycle after sampled cs.

Behaviour:
- Reset (async, immediate): state=IDLE; every output 0; timeout counter 0; last_grant=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, ACCESS, WAIT.
- IDLE, no req_valid: stay in IDLE.
- IDLE, any req_valid: winner g = first valid requester searching upward from last_grant+1, modulo NUM_REQ.
  - req_ready[g]=1 this cycle; last_grant<=g.
  - Latch we, addr and wdata into mem_we, mem_addr and mem_wdata.
- IDLE, misaligned winner (addr[1:0]!=0): accept it the same way, but next cycle resp_valid[g]=1, resp_err=1, resp_rdata=0; no mem_cs; stay in IDLE.
- IDLE, aligned winner: mem_cs<=1; go to ACCESS.
- ACCESS: mem_cs=1 for exactly this one cycle; mem_cs<=0; counter<=0; go to WAIT.
- WAIT:
  - mem_rdy=1: next cycle resp_valid[g]=1, resp_err=0, resp_rdata=mem_rdata for a read, 0 for a write; go to IDLE.
  - mem_rdy=0: counter++. At counter==TIMEOUT_CYCLES-1, next cycle resp_valid[g]=1, resp_err=1, resp_rdata=0; go to IDLE.
- mem_addr, mem_we and mem_wdata hold stable from ACCESS through WAIT and keep their values while idle. mem_we is meaningful only while mem_cs=1.
- mem_rdy is ignored outside WAIT, including a stale strobe after reset or after a timeout.
- Nominal aligned latency: accept at T, mem_cs at T+1, mem_rdy at T+2, resp_valid at T+3.
  - The cycle carrying resp_valid is IDLE and may accept the next request, so throughput is one access per 3 cycles.
- resp_valid, resp_err and resp_rdata are valid only in the strobe cycle; they return to 0 the following cycle.
- Only one access is outstanding at any time; req_ready is never asserted outside IDLE.
- Round-robin fairness: under continuous contention, every valid requester is granted within NUM_REQ grants.
- A requester deasserting req_valid before its req_ready is legal (the request is withdrawn).

Decomposition:
- Package limn2600_mem_pkg:
  - arb_state_t enum {IDLE, ACCESS, WAIT}.
  - MEM_ADDR_WIDTH=32.
  - Region base constants: RAM 16'h0000, NVRAM 16'hF800, ROM 16'hFFFE.
- One sub-module, limn2600_rr_arbiter: combinational round-robin pick. Inputs: req vector and last_grant. Outputs: one-hot grant and grant index.

Test Plan:
- Read, SRAM freshly initialised: req0 reads 0x00000010 at T -> req_ready[0] at T, mem_cs only at T+1, resp_valid[0] at T+3, resp_rdata=0x00000004, resp_err=0.
- Contention: req0 and req1 held valid after reset -> grants alternate 0,1,0,1, one grant every 3 cycles, no mem_cs overlap. After req1's grant, a new simultaneous request is granted to req0.
- Write then read: req1 writes 0xDEADBEEF to 0x00000100 -> resp_valid[1] with resp_rdata=0. Then req0 reads 0x00000100 -> resp_rdata=0xDEADBEEF.
- Misaligned: req0 reads 0x00000002 -> resp_valid[0] and resp_err=1 the next cycle, resp_rdata=0, mem_cs never asserted.
- Timeout: memory model holds mem_rdy=0 -> resp_valid with resp_err=1 exactly TIMEOUT_CYCLES(15) cycles after ACCESS. A late mem_rdy is then ignored and the next request completes normally.
- Reset mid-access: assert rst during WAIT -> all outputs 0 without waiting for a clock edge; state IDLE. A mem_rdy arriving after release causes no response. A subsequent req1 read of 0x00000008 returns 0x00000002.
